// File: rtl/obstacle_scheduler_if.sv
// Control/status bundle between the game FSM (master) and the playfield scheduler (slave).
interface obstacle_scheduler_if;
    logic        run;
    logic        clear;
    logic        game_tick;
    logic [5:0]  floor_bits;
    logic [5:0]  ceiling_bits;
    logic [3:0]  level;
    logic [15:0] tick_period;

    modport master (
        output run, clear,
        input  game_tick, floor_bits, ceiling_bits, level, tick_period
    );

    modport slave (
        input  run, clear,
        output game_tick, floor_bits, ceiling_bits, level, tick_period
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Playfield sequencer: tick time base, LFSR-driven obstacle maps with a guaranteed
// passable gap, and a level-based tick-period ramp.
module obstacle_scheduler #(
    parameter int unsigned TICK_INIT  = 50,
    parameter int unsigned TICK_MIN   = 10,
    parameter int unsigned TICK_STEP  = 2,
    parameter int unsigned RAMP_TICKS = 16,
    parameter int unsigned MIN_GAP    = 2,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input logic               clk,
    input logic               rst_n,
    obstacle_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [15:0] P_INIT    = 16'(TICK_INIT);
    localparam logic [15:0] P_MIN     = 16'(TICK_MIN);
    localparam logic [15:0] P_STEP    = 16'(TICK_STEP);
    localparam logic [16:0] P_THRESH  = 17'(TICK_MIN + TICK_STEP);
    localparam logic [7:0]  RAMP_LAST = 8'(RAMP_TICKS - 1);
    localparam logic [2:0]  GAP_NEED  = 3'(MIN_GAP);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period_q, period_d;
    logic [3:0]  level_q, level_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [2:0]  gap_q, gap_d;
    logic [7:0]  ramp_q, ramp_d;
    logic [5:0]  floor_q, floor_d;
    logic [5:0]  ceil_q, ceil_d;
    logic        tick_q, tick_d;

    logic        nf, nc;
    logic [15:0] new_period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= P_INIT;
            level_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            gap_q    <= '0;
            ramp_q   <= '0;
            floor_q  <= '0;
            ceil_q   <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            level_q  <= level_d;
            lfsr_q   <= lfsr_d;
            gap_q    <= gap_d;
            ramp_q   <= ramp_d;
            floor_q  <= floor_d;
            ceil_q   <= ceil_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        level_d    = level_q;
        lfsr_d     = lfsr_q;
        gap_d      = gap_q;
        ramp_d     = ramp_q;
        floor_d    = floor_q;
        ceil_d     = ceil_q;
        tick_d     = 1'b0;
        nf         = 1'b0;
        nc         = 1'b0;
        new_period = period_q;

        if (bus.clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            period_d = P_INIT;
            level_d  = '0;
            lfsr_d   = LFSR_SEED;
            gap_d    = '0;
            ramp_d   = '0;
            floor_d  = '0;
            ceil_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.run) begin
                        state_d = RUN;
                        cnt_d   = period_q - 16'd1;
                    end
                end
                RUN: begin
                    if (!bus.run) begin
                        state_d = HOLD;
                    end else if (cnt_q == '0) begin
                        tick_d = 1'b1;
                        if (gap_q >= GAP_NEED) begin
                            nf = (lfsr_q[1:0] == 2'b01);
                            nc = (lfsr_q[1:0] == 2'b10);
                        end
                        floor_d = {floor_q[4:0], nf};
                        ceil_d  = {ceil_q[4:0], nc};
                        gap_d   = (nf | nc) ? 3'd0 : ((gap_q == 3'd7) ? gap_q : gap_q + 3'd1);
                        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                        // Ramp freezes once level saturates; reload below uses the updated period.
                        if (level_q != 4'd15) begin
                            if (ramp_q == RAMP_LAST) begin
                                ramp_d     = '0;
                                level_d    = level_q + 4'd1;
                                new_period = ({1'b0, period_q} > P_THRESH) ? (period_q - P_STEP) : P_MIN;
                            end else begin
                                ramp_d = ramp_q + 8'd1;
                            end
                        end
                        period_d = new_period;
                        cnt_d    = new_period - 16'd1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                HOLD: begin
                    if (bus.run) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.game_tick    = tick_q;
    assign bus.floor_bits   = floor_q;
    assign bus.ceiling_bits = ceil_q;
    assign bus.level        = level_q;
    assign bus.tick_period  = period_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Randomized self-checking bench for obstacle_scheduler against a tick-counting playfield model.
module tb_obstacle_scheduler;

    localparam int TICK_INIT  = 4;
    localparam int TICK_MIN   = 2;
    localparam int TICK_STEP  = 1;
    localparam int RAMP_TICKS = 3;
    localparam int MIN_GAP    = 2;

    logic clk = 1'b0;
    logic rst_n;

    obstacle_scheduler_if bus();

    obstacle_scheduler #(
        .TICK_INIT (TICK_INIT),
        .TICK_MIN  (TICK_MIN),
        .TICK_STEP (TICK_STEP),
        .RAMP_TICKS(RAMP_TICKS),
        .MIN_GAP   (MIN_GAP),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: counts active cycles up to the current period; level derives from total ticks.
    int         m_elapsed, m_ticks, m_since;
    bit         m_prev_ok, m_tick;
    bit         m_floor[6];
    bit         m_ceil[6];
    logic [7:0] m_lfsr;

    int cyc = 0;
    int tick_edges[$];
    bit prev_dut_tick = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_level();
        int l = m_ticks / RAMP_TICKS;
        return (l > 15) ? 15 : l;
    endfunction

    function automatic int m_period();
        int p = TICK_INIT - m_level() * TICK_STEP;
        return (p < TICK_MIN) ? TICK_MIN : p;
    endfunction

    task automatic m_clear();
        m_elapsed = 0;
        m_ticks   = 0;
        m_since   = 0;
        m_prev_ok = 1'b0;
        m_tick    = 1'b0;
        m_lfsr    = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            m_floor[i] = 1'b0;
            m_ceil[i]  = 1'b0;
        end
    endtask

    task automatic m_spawn();
        bit nf, nc;
        nf = (m_since >= MIN_GAP) && (m_lfsr[1:0] == 2'b01);
        nc = (m_since >= MIN_GAP) && (m_lfsr[1:0] == 2'b10);
        for (int i = 5; i > 0; i--) begin
            m_floor[i] = m_floor[i-1];
            m_ceil[i]  = m_ceil[i-1];
        end
        m_floor[0] = nf;
        m_ceil[0]  = nc;
        m_since = (nf || nc) ? 0 : m_since + 1;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
    endtask

    // Compare process: advance model per edge, check DUT 1 time unit later.
    initial begin
        logic [5:0] mf, mc, occ;
        m_clear();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n || bus.clear) begin
                m_clear();
            end else begin
                m_tick = 1'b0;
                if (bus.run && m_prev_ok) begin
                    m_elapsed++;
                    if (m_elapsed >= m_period()) begin
                        m_tick    = 1'b1;
                        m_elapsed = 0;
                        m_spawn();
                        m_ticks++;
                    end
                end
                m_prev_ok = bus.run;
            end
            #1;
            if (rst_n) begin
                for (int i = 0; i < 6; i++) begin
                    mf[i] = m_floor[i];
                    mc[i] = m_ceil[i];
                end
                chk("game_tick", 32'(bus.game_tick), 32'(m_tick));
                chk("floor_bits", 32'(bus.floor_bits), 32'(mf));
                chk("ceiling_bits", 32'(bus.ceiling_bits), 32'(mc));
                chk("level", 32'(bus.level), m_level());
                chk("tick_period", 32'(bus.tick_period), m_period());
                chk("overlap", 32'(bus.floor_bits & bus.ceiling_bits), 0);
                occ = bus.floor_bits | bus.ceiling_bits;
                chk("spacing", 32'((occ & (occ >> 1)) | (occ & (occ >> 2))), 0);
                chk("double_tick", 32'(prev_dut_tick & bus.game_tick), 0);
                if (bus.game_tick === 1'b1) tick_edges.push_back(cyc);
                prev_dut_tick = bus.game_tick;
            end else begin
                prev_dut_tick = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ticks(input int target, input int budget);
        int n = 0;
        while (tick_edges.size() < target && n < budget) begin
            step();
            n++;
        end
        if (tick_edges.size() < target) begin
            checks++;
            errors++;
            $display("FAIL tick_wait: got %0d ticks expected %0d", tick_edges.size(), target);
        end
    endtask

    initial begin
        int k0, base, n0, resume_edge, budget;
        rst_n     = 1'b0;
        bus.run   = 1'b0;
        bus.clear = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_period", 32'(bus.tick_period), 4);
        chk("rst_floor", 32'(bus.floor_bits), 0);
        chk("rst_tick", 32'(bus.game_tick), 0);

        // Start from IDLE: ticks at +4, +8, +12, then +15 after the first level-up
        tick_edges.delete();
        k0 = cyc + 1;
        bus.run = 1'b1;
        wait_ticks(4, 40);
        if (tick_edges.size() >= 4) begin
            chk("tick1_edge", tick_edges[0] - k0, 4);
            chk("tick2_edge", tick_edges[1] - k0, 8);
            chk("tick3_edge", tick_edges[2] - k0, 12);
            chk("tick4_edge", tick_edges[3] - k0, 15);
        end
        chk("level_after_3", 32'(bus.level), 1);
        chk("period_after_3", 32'(bus.tick_period), 3);

        // Ramp to saturation
        wait_ticks(44, 400);
        chk("level_44", 32'(bus.level), 14);
        wait_ticks(45, 20);
        chk("level_45", 32'(bus.level), 15);
        chk("period_floor", 32'(bus.tick_period), 2);

        // Pause two cycles after a tick for five cycles
        wait_ticks(tick_edges.size() + 1, 20);
        step();
        bus.run = 1'b0;
        n0 = tick_edges.size();
        repeat (5) step();
        chk("pause_no_tick", tick_edges.size(), n0);
        resume_edge = cyc;
        bus.run = 1'b1;
        wait_ticks(n0 + 1, 20);
        if (tick_edges.size() > n0) chk("resume_latency", tick_edges[n0] - resume_edge, 2);

        // Randomized run/pause/clear over 500 ticks
        base = tick_edges.size();
        budget = 0;
        while (tick_edges.size() < base + 500 && budget < 6000) begin
            bus.run   = ($urandom_range(0, 7) != 0);
            bus.clear = ($urandom_range(0, 299) == 0);
            step();
            budget++;
        end
        if (tick_edges.size() < base + 500) begin
            checks++;
            errors++;
            $display("FAIL random_ticks: got %0d ticks expected %0d", tick_edges.size() - base, 500);
        end
        bus.clear = 1'b0;
        bus.run   = 1'b1;
        repeat (3) step();

        // Clear with Run high
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr_floor", 32'(bus.floor_bits), 0);
        chk("clr_ceil", 32'(bus.ceiling_bits), 0);
        chk("clr_level", 32'(bus.level), 0);
        chk("clr_period", 32'(bus.tick_period), 4);
        chk("clr_tick", 32'(bus.game_tick), 0);
        k0 = cyc + 1;
        base = tick_edges.size();
        wait_ticks(base + 2, 30);
        if (tick_edges.size() >= base + 2) begin
            chk("clr_first_tick", tick_edges[base] - k0, 4);
            chk("clr_second_tick", tick_edges[base + 1] - k0, 8);
        end
        chk("first_cols_empty", 32'(bus.floor_bits | bus.ceiling_bits), 0);

        // Asynchronous reset mid-run, checked before the next clock edge
        wait_ticks(tick_edges.size() + 8, 60);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_tick", 32'(bus.game_tick), 0);
        chk("arst_floor", 32'(bus.floor_bits), 0);
        chk("arst_ceil", 32'(bus.ceiling_bits), 0);
        chk("arst_level", 32'(bus.level), 0);
        chk("arst_period", 32'(bus.tick_period), 4);
        step();
        rst_n = 1'b1;
        tick_edges.delete();
        repeat (40) begin
            bus.run = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
